// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: issue stage in front of the 16-bit ALU.
// Holds the register file, reads the source operands, forms A/B/ALUOp and
// registers one issued op behind a valid/ready handshake. A per-register
// pending scoreboard stalls ops whose sources still have writes in flight.
// Optional build macro: OFS_BYPASS_EN enables write-through forwarding of
// the writeback port into operand reads and hazard resolution.
module operand_fetch_stage #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_aluop,
    input  logic [AW-1:0]    in_rs,
    input  logic [AW-1:0]    in_rt,
    input  logic [AW-1:0]    in_rd,
    input  logic             in_wr_en,
    input  logic             in_use_imm,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [3:0]       in_shamt,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       ALUOp,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [AW-1:0]    out_rd,
    output logic             out_wr_en
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;

    logic             out_valid_q, out_valid_d;
    logic [2:0]       aluop_q, aluop_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic             wr_en_q, wr_en_d;

    logic [WIDTH-1:0] rs_val, rt_val;
    logic             rs_pend, rt_pend;
    logic             is_shift, rt_used, hazard, accept;

    // Source reads and their pending state; R0 is hardwired to zero and never pending
    always_comb begin
        rs_val  = (in_rs == '0) ? '0 : regs_q[in_rs];
        rt_val  = (in_rt == '0) ? '0 : regs_q[in_rt];
        rs_pend = pending_q[in_rs];
        rt_pend = pending_q[in_rt];
`ifdef OFS_BYPASS_EN
        // A source being written back this cycle takes the incoming data and is resolved
        if (wb_en && (wb_addr == in_rs) && (in_rs != '0)) begin
            rs_val  = wb_data;
            rs_pend = 1'b0;
        end
        if (wb_en && (wb_addr == in_rt) && (in_rt != '0)) begin
            rt_val  = wb_data;
            rt_pend = 1'b0;
        end
`endif
    end

    // Hazard detection and the input handshake
    always_comb begin
        is_shift = (in_aluop >= 3'b101);
        rt_used  = !is_shift && !in_use_imm;
        hazard   = rs_pend || (rt_used && rt_pend);
        in_ready = (!out_valid_q || out_ready) && !hazard;
        accept   = in_valid && in_ready;
    end

    // Output register next state: load on accept, drop valid once consumed, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        aluop_d     = aluop_q;
        a_d         = a_q;
        b_d         = b_q;
        rd_d        = rd_q;
        wr_en_d     = wr_en_q;
        if (accept) begin
            out_valid_d = 1'b1;
            aluop_d     = in_aluop;
            rd_d        = in_rd;
            wr_en_d     = in_wr_en;
            if (is_shift) begin
                a_d = {{(WIDTH-4){1'b0}}, in_shamt};
                b_d = rs_val;
            end else begin
                a_d = rs_val;
                b_d = in_use_imm ? in_imm : rt_val;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Scoreboard next state: writeback clears, a new writer sets; set applied last so it wins
    always_comb begin
        pending_d = pending_q;
        if (wb_en) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (accept && in_wr_en && (in_rd != '0)) begin
            pending_d[in_rd] = 1'b1;
        end
    end

    // Register file next state; writes to R0 are discarded
    always_comb begin
        regs_d = regs_q;
        if (wb_en && (wb_addr != '0)) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // All state flops, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            aluop_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            wr_en_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            aluop_q     <= aluop_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            wr_en_q     <= wr_en_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ALUOp     = aluop_q;
    assign A         = a_q;
    assign B         = b_q;
    assign out_rd    = rd_q;
    assign out_wr_en = wr_en_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed testbench for operand_fetch_stage. Expected values are hand-derived.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_aluop = '0;
    logic [2:0]  in_rs = '0;
    logic [2:0]  in_rt = '0;
    logic [2:0]  in_rd = '0;
    logic        in_wr_en = 1'b0;
    logic        in_use_imm = 1'b0;
    logic [15:0] in_imm = '0;
    logic [3:0]  in_shamt = '0;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  ALUOp;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  out_rd;
    logic        out_wr_en;

    int checks = 0;
    int errors = 0;

    operand_fetch_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_wr_en(in_wr_en), .in_use_imm(in_use_imm), .in_imm(in_imm), .in_shamt(in_shamt),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUOp(ALUOp), .A(A), .B(B), .out_rd(out_rd), .out_wr_en(out_wr_en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                          input logic [2:0] rd, input logic wr, input logic use_imm,
                          input logic [15:0] imm, input logic [3:0] shamt);
        in_aluop = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_wr_en = wr; in_use_imm = use_imm; in_imm = imm; in_shamt = shamt;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_op(3'd0, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 16'h0, 4'h0);
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (A !== 16'h0) begin errors++; $display("FAIL reset_A got %h want 0000", A); end
        checks++; if (B !== 16'h0) begin errors++; $display("FAIL reset_B got %h want 0000", B); end
        checks++; if (ALUOp !== 3'd0 || out_rd !== 3'd0 || out_wr_en !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got op=%0d rd=%0d wr=%0b want 0/0/0", ALUOp, out_rd, out_wr_en); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        reset = 1'b0;
        $display("reset: outputs cleared");
    endtask

    task automatic test_add_imm();
        set_op(3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 16'h1234, 4'h0);
        in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %0b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %0b want 1", out_valid); end
        checks++; if (A !== 16'h0000 || B !== 16'h1234) begin errors++; $display("FAIL add_AB got %h/%h want 0000/1234", A, B); end
        checks++; if (ALUOp !== 3'd0 || out_rd !== 3'd1 || out_wr_en !== 1'b1) begin
            errors++; $display("FAIL add_ctrl got op=%0d rd=%0d wr=%0b want 0/1/1", ALUOp, out_rd, out_wr_en); end
        set_op(3'd0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0, 4'h0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_pending1 in_ready got %0b want 0", in_ready); end
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h8000;
        step();
        wb_en = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain out_valid got %0b want 0", out_valid); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_wb_clear in_ready got %0b want 1", in_ready); end
        $display("add R1,R0,#1234: A=%h B=%h op=%0d", A, B, ALUOp);
    endtask

    task automatic test_shift();
        set_op(3'd6, 3'd1, 3'd7, 3'd2, 1'b1, 1'b0, 16'h0, 4'd5);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (A !== 16'h0005 || B !== 16'h8000) begin errors++; $display("FAIL shr_AB got %h/%h want 0005/8000", A, B); end
        checks++; if (ALUOp !== 3'd6 || out_rd !== 3'd2) begin errors++; $display("FAIL shr_ctrl got op=%0d rd=%0d want 6/2", ALUOp, out_rd); end
        // R2 now pending: a shift ignores rt, a register-register op does not
        set_op(3'd7, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0, 16'h0, 4'd1);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL shift_rt_unused in_ready got %0b want 1", in_ready); end
        set_op(3'd0, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0, 16'h0, 4'd0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rt_hazard in_ready got %0b want 0", in_ready); end
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h0400;
        step();
        wb_en = 1'b0;
        $display("shr R2,R1,5: done");
    endtask

    task automatic test_hazard();
        set_op(3'd0, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 16'h0007, 4'd0);
        in_valid = 1'b1;
        step();
        set_op(3'd1, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0001, 4'd0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_c0 in_ready got %0b want 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_c1 in_ready got %0b want 0", in_ready); end
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h0055;
        #1;
`ifdef OFS_BYPASS_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_wb_cycle in_ready got %0b want 1", in_ready); end
        step();
        wb_en = 1'b0; in_valid = 1'b0;
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_wb_cycle in_ready got %0b want 0", in_ready); end
        step();
        wb_en = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hazard_no_issue out_valid got %0b want 0", out_valid); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_after_wb in_ready got %0b want 1", in_ready); end
        step();
        in_valid = 1'b0;
`endif
        checks++; if (out_valid !== 1'b1 || A !== 16'h0055 || B !== 16'h0001 || ALUOp !== 3'd1) begin
            errors++; $display("FAIL hazard_issue got v=%0b A=%h B=%h op=%0d want 1/0055/0001/1", out_valid, A, B, ALUOp); end
        step();
        $display("hazard on R3: issued A=%h", A);
    endtask

    task automatic test_wb_read();
        logic [15:0] exp_a;
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'h1111;
        step();
        wb_data = 16'h2222;
        set_op(3'd0, 3'd6, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0, 4'd0);
        in_valid = 1'b1;
        step();
        wb_en = 1'b0; in_valid = 1'b0;
`ifdef OFS_BYPASS_EN
        exp_a = 16'h2222;
`else
        exp_a = 16'h1111;
`endif
        checks++; if (A !== exp_a) begin errors++; $display("FAIL same_cycle_read A got %h want %h", A, exp_a); end
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
        step();
        wb_en = 1'b0;
        set_op(3'd0, 3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 16'h0, 4'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (A !== 16'h0000 || B !== 16'h2222) begin errors++; $display("FAIL r0_and_r6 got %h/%h want 0000/2222", A, B); end
        $display("writeback read-through: A=%h B=%h", A, B);
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        set_op(3'd2, 3'd6, 3'd0, 3'd7, 1'b1, 1'b1, 16'h0F0F, 4'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %0b want 0", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || A !== 16'h0000 || B !== 16'h2222 || ALUOp !== 3'd0) begin
                errors++; $display("FAIL stall_hold[%0d] got v=%0b A=%h B=%h op=%0d want 1/0000/2222/0", i, out_valid, A, B, ALUOp); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        set_op(3'd0, 3'd7, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0, 4'd0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_no_pending7 in_ready got %0b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release out_valid got %0b want 0", out_valid); end
        $display("backpressure 4 cycles: held");
    endtask

    task automatic test_same_edge();
        set_op(3'd0, 3'd0, 3'd0, 3'd4, 1'b1, 1'b1, 16'h0000, 4'd0);
        in_valid = 1'b1;
        step();
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h4444;
        in_imm = 16'h0001;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL same_edge_in_ready got %0b want 1", in_ready); end
        step();
        wb_en = 1'b0; in_valid = 1'b0;
        checks++; if (B !== 16'h0001) begin errors++; $display("FAIL same_edge_issue B got %h want 0001", B); end
        set_op(3'd0, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0, 4'd0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL same_edge_pending4 in_ready got %0b want 0", in_ready); end
        checks++; if (dut.regs_q[4] !== 16'h4444) begin errors++; $display("FAIL same_edge_reg4 got %h want 4444", dut.regs_q[4]); end
        step();
        $display("same-edge set/clear on R4: set wins");
    endtask

    task automatic test_reset_mid();
        set_op(3'd0, 3'd0, 3'd0, 3'd5, 1'b1, 1'b1, 16'h00C3, 4'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || B !== 16'h00C3) begin errors++; $display("FAIL mid_setup got v=%0b B=%h want 1/00C3", out_valid, B); end
        set_op(3'd0, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 16'h0, 4'd0);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || B !== 16'h0000 || out_wr_en !== 1'b0) begin
            errors++; $display("FAIL mid_reset_out got v=%0b B=%h wr=%0b want 0/0000/0", out_valid, B, out_wr_en); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_pending5 in_ready got %0b want 1", in_ready); end
        step();
        reset = 1'b0; out_ready = 1'b1;
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h5A5A;
        step();
        wb_en = 1'b0;
        set_op(3'd0, 3'd5, 3'd6, 3'd0, 1'b0, 1'b0, 16'h0, 4'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (A !== 16'h5A5A || B !== 16'h0000) begin errors++; $display("FAIL mid_after_wb got %h/%h want 5A5A/0000", A, B); end
        $display("reset mid-op: dropped, late writeback A=%h", A);
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_shift();
        test_hazard();
        test_wb_read();
        test_stall();
        test_same_edge();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
